pipe_reg_chain: RTL and testbench
=================================

# pipe_reg_chain

Parametrised, elastic pipeline register chain for the multiplier datapath: WL-bit words pass through DEPTH register stages, each with its own valid bit and a ready/valid handshake on both ends. Backpressure stalls stages individually and collapses bubbles. A synchronous flush discards all in-flight words. It replaces single-stage, always-enabled pipeline registers between multiplier partial-product and accumulate stages where downstream logic can stall.

## Interface
- WL, 4, data word width in bits (>=1)
- DEPTH, 3, number of register stages (>=1)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous discard of all in-flight words
- in_valid  input  1  upstream word present on in_data
- in_ready  output  1  chain accepts in_data this cycle
- in_data  input  WL  upstream word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WL  oldest word in the chain
- count  output  $clog2(DEPTH+1)  number of occupied stages, 0..DEPTH

## Operation
- Stages 0..DEPTH-1; stage 0 is loaded from in_data, stage DEPTH-1 drives out_data/out_valid. Each stage k holds v[k] and d[k].
- Stage readiness, combinational: r[DEPTH] = out_ready; r[k] = !v[k] || r[k+1]. in_ready = r[0] && !flush.
- Transfer into stage k occurs when its source is valid (in_valid for k=0, v[k-1] otherwise) and r[k]=1. On transfer d[k] loads source data and v[k]=1; if stage k is emptied downstream with no incoming transfer, v[k]=0.
- d[k] changes only on a load; a stalled stage holds its data. out_data stays stable while out_valid && !out_ready.
- Bubbles collapse: an empty stage accepts from upstream even when out_ready=0.
- Output transfer: out_valid && out_ready at an edge.
- count = number of v[k] set; registered (updated on the same edge as v).
- flush=1: at next edge all v[k] cleared, count=0; in_ready=0 and out_valid=0 during the flush cycle, so no transfer occurs on either side. d[k] not required to clear.
- Priority: rst > flush > normal operation.

## Timing
- Reset: v[k]=0, d[k]=0 for all k; out_valid=0, out_data=0, count=0; in_ready=1 once rst deasserts (with flush=0).
- Latency: word accepted at edge E into an empty chain, out_ready=1: out_valid high with that word after edge E+DEPTH-1 (DEPTH=1: visible right after acceptance edge).
- Throughput: 1 word/cycle sustained while in_valid=out_ready=1, no bubbles inserted.
- Full: count=DEPTH and out_ready=0 -> in_ready=0. Full and out_ready=1 -> in_ready=1; simultaneous in/out transfer keeps count=DEPTH.
- Empty: count=0 -> out_valid=0, in_ready=1 regardless of out_ready.
- Simultaneous in and out transfer: count unchanged.
- in_ready and out_valid have combinational dependence only on out_ready, flush and registered state; no path from in_valid/in_data to in_ready.
- rst asserted mid-stream: all in-flight words dropped; state as reset value after that edge.
- flush and in_valid in same cycle: input word not accepted (in_ready=0).

## Test plan
- WL=8, DEPTH=3, reset, then in_valid=1 with 0x11,0x22,0x33 on consecutive edges, out_ready=1 -> 0x11 at out after third edge, then 0x22, 0x33 on consecutive cycles; count peaks at 3, returns to 0.
- Fill with 0x01..0x03, out_ready=0 -> count=3, in_ready=0, out_data=0x01 stable every cycle; raise out_ready with in_valid=1 data 0x04 -> 0x01 out and 0x04 accepted on same edge, count stays 3.
- Bubble collapse: load 0xA0, idle one cycle, load 0xB0 with out_ready=0 -> both stages compact, count=2, third word 0xC0 still accepted (in_ready=1).
- Flush with count=2 and in_valid=1 data 0xEE -> in_ready=0, out_valid=0 that cycle; next cycle count=0, out_valid=0; 0xEE never appears at output.
- rst asserted with count=3 and flush=1 -> next cycle out_valid=0, out_data=0, count=0, in_ready=1.
- DEPTH=1, WL=4: stream 0x5,0x6 with out_ready toggling 1,0,1 -> each word visible after its acceptance edge, held under stall, no loss or duplication.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register chain: DEPTH ready/valid stages of WL-bit words.
// Stalls propagate per stage so bubbles collapse; flush drops all in-flight words.
module pipe_reg_chain #(
    parameter int WL    = 4,
    parameter int DEPTH = 3,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_data,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WL-1:0]    data_q [DEPTH];
    logic [WL-1:0]    data_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] src_valid;
    logic [DEPTH-1:0] load;
    logic [WL-1:0]    src_data [DEPTH];

    always_comb begin
        rdy        = '0;
        src_valid  = '0;
        load       = '0;
        valid_d    = '0;
        count_d    = '0;
        src_data   = '{default: '0};
        data_d     = data_q;

        // A stage is ready when empty or when everything below it will move.
        rdy[DEPTH] = out_ready;
        for (int unsigned k = DEPTH; k > 0; k--) begin
            rdy[k-1] = !valid_q[k-1] || rdy[k];
        end

        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
        end

        for (int unsigned k = 0; k < DEPTH; k++) begin
            load[k]    = src_valid[k] && rdy[k] && !flush;
            valid_d[k] = !flush && (load[k] || (valid_q[k] && !rdy[k+1]));
            if (load[k]) begin
                data_d[k] = src_data[k];
            end
            count_d = count_d + CW'(valid_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = valid_q[DEPTH-1] && !flush;
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a DEPTH=3/WL=8 and a DEPTH=1/WL=4 instance share stimulus
// and are checked every cycle against a word-position queue model.
module tb_pipe_reg_chain;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;

    logic       in_ready3, out_valid3;
    logic [7:0] out_data3;
    logic [1:0] count3;
    logic       in_ready1, out_valid1;
    logic [3:0] out_data1;
    logic [0:0] count1;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model: each instance holds an ordered list of words (oldest first) with stage position.
    int         mn [2] = '{0, 0};
    int         mp [2][4];
    logic [7:0] md [2][4];

    always #5 clk = ~clk;

    pipe_reg_chain #(.WL(8), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .count(count3)
    );

    pipe_reg_chain #(.WL(4), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data[3:0]),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .count(count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval(input int id, input bit commit,
                              output bit p_ir, output bit p_ov, output logic [7:0] p_od);
        int d, nn, lim, np;
        int tp [4];
        logic [7:0] td [4];
        logic [7:0] mask;
        bit slot0_free;
        d    = (id == 0) ? 3 : 1;
        mask = (id == 0) ? 8'hFF : 8'h0F;
        nn   = 0;
        lim  = d;
        p_ov = !flush && mn[id] > 0 && mp[id][0] == d - 1;
        p_od = md[id][0];
        for (int i = 0; i < mn[id]; i++) begin
            if (!(i == 0 && mp[id][0] == d - 1 && out_ready)) begin
                np = (mp[id][i] + 1 < lim) ? mp[id][i] + 1 : mp[id][i];
                tp[nn] = np;
                td[nn] = md[id][i];
                nn++;
                lim = np;
            end
        end
        slot0_free = 1'b1;
        if (nn > 0) slot0_free = (tp[nn-1] > 0);
        p_ir = !flush && slot0_free;
        if (commit) begin
            if (rst || flush) begin
                mn[id] = 0;
            end else begin
                if (in_valid && p_ir) begin
                    tp[nn] = 0;
                    td[nn] = in_data & mask;
                    nn++;
                end
                mn[id] = nn;
                for (int i = 0; i < nn; i++) begin
                    mp[id][i] = tp[i];
                    md[id][i] = td[i];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        bit a, b;
        logic [7:0] c;
        model_eval(0, 1'b1, a, b, c);
        model_eval(1, 1'b1, a, b, c);
    end

    always @(negedge clk) begin
        bit p_ir, p_ov;
        logic [7:0] p_od;
        if (started && !rst) begin
            model_eval(0, 1'b0, p_ir, p_ov, p_od);
            check("d3_in_ready", 32'(in_ready3), 32'(p_ir));
            check("d3_out_valid", 32'(out_valid3), 32'(p_ov));
            check("d3_count", 32'(count3), 32'(mn[0]));
            if (p_ov) check("d3_out_data", 32'(out_data3), 32'(p_od));
            model_eval(1, 1'b0, p_ir, p_ov, p_od);
            check("d1_in_ready", 32'(in_ready1), 32'(p_ir));
            check("d1_out_valid", 32'(out_valid1), 32'(p_ov));
            check("d1_count", 32'(count1), 32'(mn[1]));
            if (p_ov) check("d1_out_data", 32'(out_data1), 32'(p_od));
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        cyc(2);
        check("rst_out_valid", 32'(out_valid3), 32'd0);
        check("rst_out_data", 32'(out_data3), 32'd0);
        check("rst_count", 32'(count3), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready3), 32'd1);
        started = 1'b1;

        // Latency and streaming
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; cyc();
        in_data = 8'h22; cyc();
        in_data = 8'h33; cyc();
        in_valid = 1'b0;
        check("lat_out_valid", 32'(out_valid3), 32'd1);
        check("lat_out_data", 32'(out_data3), 32'h11);
        check("lat_count", 32'(count3), 32'd3);
        cyc();
        check("lat_second", 32'(out_data3), 32'h22);
        cyc(3);
        check("lat_drained", 32'(count3), 32'd0);

        // Full with backpressure, then simultaneous in/out
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h01; cyc();
        in_data = 8'h02; cyc();
        in_data = 8'h03; cyc();
        in_valid = 1'b0;
        check("full_count", 32'(count3), 32'd3);
        check("full_in_ready", 32'(in_ready3), 32'd0);
        check("full_hold", 32'(out_data3), 32'h01);
        cyc(2);
        check("full_hold2", 32'(out_data3), 32'h01);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h04;
        #1;
        check("full_release_ready", 32'(in_ready3), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("full_swap_count", 32'(count3), 32'd3);
        check("full_swap_data", 32'(out_data3), 32'h02);
        cyc(4);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA0; cyc();
        in_valid = 1'b0; cyc();
        in_valid = 1'b1; in_data = 8'hB0; cyc();
        check("bub_count", 32'(count3), 32'd2);
        in_data = 8'hC0;
        #1;
        check("bub_in_ready", 32'(in_ready3), 32'd1);
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b1; cyc(4);

        // Flush with words in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h21; cyc();
        in_data = 8'h22; cyc();
        flush = 1'b1; in_data = 8'hEE;
        #1;
        check("fl_in_ready", 32'(in_ready3), 32'd0);
        check("fl_out_valid", 32'(out_valid3), 32'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count", 32'(count3), 32'd0);
        check("fl_out_valid_after", 32'(out_valid3), 32'd0);
        out_ready = 1'b1; cyc(4);

        // Reset dominates flush with a full chain
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h31; cyc();
        in_data = 8'h32; cyc();
        in_data = 8'h33; cyc();
        check("rf_full", 32'(count3), 32'd3);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b0;
        cyc();
        rst = 1'b0; flush = 1'b0;
        #1;
        check("rf_out_valid", 32'(out_valid3), 32'd0);
        check("rf_out_data", 32'(out_data3), 32'd0);
        check("rf_count", 32'(count3), 32'd0);
        check("rf_in_ready", 32'(in_ready3), 32'd1);

        // Single-stage instance under toggling backpressure
        in_valid = 1'b1; in_data = 8'h05; out_ready = 1'b1; cyc();
        check("d1_first_valid", 32'(out_valid1), 32'd1);
        check("d1_first_data", 32'(out_data1), 32'h5);
        in_data = 8'h06; out_ready = 1'b0;
        #1;
        check("d1_stall_ready", 32'(in_ready1), 32'd0);
        cyc();
        check("d1_stall_hold", 32'(out_data1), 32'h5);
        out_ready = 1'b1; cyc();
        check("d1_second_data", 32'(out_data1), 32'h6);
        in_valid = 1'b0; cyc();
        check("d1_empty", 32'(out_valid1), 32'd0);

        // Randomized traffic with varying backpressure bias
        for (int i = 0; i < 2000; i++) begin
            int bias;
            bias      = (i / 200) % 4;
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) < 32'(bias + 1));
            in_data   = 8'($urandom);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
